// File: rtl/ysyx_22050854_pkg.sv
// Shared types and constants for the ysyx_22050854 instruction fetch unit.
package ysyx_22050854_pkg;

    typedef enum logic [2:0] {
        IFU_IDLE  = 3'd0,
        IFU_ADDR  = 3'd1,
        IFU_DATA  = 3'd2,
        IFU_DRAIN = 3'd3,
        IFU_OUT   = 3'd4
    } ifu_state_e;

    localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    // Instructions are 4-byte aligned; any low bit set is a fetch fault.
    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22050854_inst_sel.sv
// Picks the 32-bit instruction out of a 64-bit memory beat using pc[2].
module ysyx_22050854_inst_sel
    import ysyx_22050854_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic        hi_sel,
    output logic [31:0] word
);

    assign word = hi_sel ? rdata[63:32] : rdata[31:0];

endmodule

// File: rtl/ysyx_22050854_ifu.sv
// Instruction fetch unit: one 64-bit read per pc, word select, decoder handshake.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
module ysyx_22050854_ifu
    import ysyx_22050854_pkg::*;
#(
    parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    output logic        arvalid,
    output logic [31:0] araddr,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        inst_fault,
    output logic [63:0] fetch_cnt
);

    ifu_state_e  state_q, state_d;
    logic        flush_seen_q, flush_seen_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_fault_q, inst_fault_d;
    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        inst_valid_q, inst_valid_d;
    logic        pc_fire;
    logic [31:0] sel_word;

    // inst_pc_q doubles as the latched fetch pc while the read is in flight.
    ysyx_22050854_inst_sel u_inst_sel (
        .rdata  (rdata),
        .hi_sel (inst_pc_q[2]),
        .word   (sel_word)
    );

    assign pc_ready = !flush && ((state_q == IFU_IDLE) ||
                                 ((state_q == IFU_OUT) && inst_ready));
    assign pc_fire  = pc_valid && pc_ready;

    always_comb begin
        state_d      = state_q;
        flush_seen_d = flush_seen_q;
        araddr_d     = araddr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        fetch_cnt_d  = fetch_cnt_q;

        case (state_q)
            IFU_IDLE: begin
                state_d = IFU_IDLE;
            end
            IFU_ADDR: begin
                // arvalid must not drop, so a flush here is remembered and the
                // response is drained once the address has been accepted.
                if (flush) begin
                    flush_seen_d = 1'b1;
                end
                if (arready) begin
                    state_d      = (flush_seen_q || flush) ? IFU_DRAIN : IFU_DATA;
                    flush_seen_d = 1'b0;
                end
            end
            IFU_DATA: begin
                if (rvalid) begin
                    if (flush) begin
                        state_d = IFU_IDLE;
                    end else begin
                        state_d      = IFU_OUT;
                        inst_d       = sel_word;
                        inst_fault_d = (rresp != RESP_OKAY);
                    end
                end else if (flush) begin
                    state_d = IFU_DRAIN;
                end
            end
            IFU_DRAIN: begin
                if (rvalid) begin
                    state_d = IFU_IDLE;
                end
            end
            IFU_OUT: begin
                if (flush) begin
                    state_d = IFU_IDLE;
                end else if (inst_ready) begin
                    state_d     = IFU_IDLE;
                    fetch_cnt_d = fetch_cnt_q + 64'd1;
                end
            end
            default: begin
                state_d = IFU_IDLE;
            end
        endcase

        // pc_fire is only possible in IDLE or in a completing OUT cycle.
        if (pc_fire) begin
            inst_pc_d = pc;
            if (is_misaligned(pc[1:0])) begin
                state_d      = IFU_OUT;
                inst_d       = NOP_INST;
                inst_fault_d = 1'b1;
            end else begin
                state_d  = IFU_ADDR;
                araddr_d = {pc[31:3], 3'b000};
            end
        end

        if (state_d != IFU_OUT) begin
            inst_d       = NOP_INST;
            inst_fault_d = 1'b0;
        end

        arvalid_d    = (state_d == IFU_ADDR);
        rready_d     = (state_d == IFU_DATA) || (state_d == IFU_DRAIN);
        inst_valid_d = (state_d == IFU_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IFU_IDLE;
            flush_seen_q <= 1'b0;
            araddr_q     <= 32'd0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= 32'd0;
            inst_fault_q <= 1'b0;
            fetch_cnt_q  <= 64'd0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_seen_q <= flush_seen_d;
            araddr_q     <= araddr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
            fetch_cnt_q  <= fetch_cnt_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign arvalid    = arvalid_q;
    assign araddr     = araddr_q;
    assign rready     = rready_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign inst_fault = inst_fault_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_22050854_ifu.sv
// Bench for ysyx_22050854_ifu: directed scenarios then random traffic against a
// transaction-level model with a memory responder and an output scoreboard.
module tb_ysyx_22050854_ifu;
    import ysyx_22050854_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst;
    logic [31:0] pc;
    logic        pc_valid, pc_ready, flush;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] inst, inst_pc;
    logic        inst_valid, inst_ready, inst_fault;
    logic [63:0] fetch_cnt;

    ysyx_22050854_ifu dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .flush      (flush),
        .arvalid    (arvalid),
        .araddr     (araddr),
        .arready    (arready),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rready     (rready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_fault (inst_fault),
        .fetch_cnt  (fetch_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [64:0] exp_q[$];      // {fault, pc, inst}
    logic [31:0] addr_q[$];
    logic [1:0]  rresp_q[$];
    logic [63:0] exp_cnt = 64'd0;
    int          force_resp = 0;
    int          ar_mode = 1;   // 0 random, 1 always ready, 2 never ready
    int          rwait_min = 0;
    int          rwait_max = 0;
    logic        last_acc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_read(input logic [31:0] a);
        if (a == 32'h8000_0000) return 64'h1234_5678_0010_0073;
        return {a ^ 32'hdead_beef, ~a};
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle of decoder/pc-side inputs and records what the model expects.
    task automatic cycle(input logic pv, input logic [31:0] p, input logic fl, input logic ir);
        logic [63:0] d;
        logic [1:0]  rr;
        logic [31:0] w;
        pc_valid   = pv;
        pc         = p;
        flush      = fl;
        inst_ready = ir;
        @(negedge clk);
        #1;
        last_acc = !rst && pc_valid && pc_ready;
        if (flush && !rst) exp_q.delete();
        if (last_acc) begin
            if (p[1:0] != 2'b00) begin
                exp_q.push_back({1'b1, p, NOP});
            end else begin
                if (force_resp >= 0) rr = 2'(force_resp);
                else rr = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
                rresp_q.push_back(rr);
                addr_q.push_back({p[31:3], 3'b000});
                d = mem_read({p[31:3], 3'b000});
                w = p[2] ? d[63:32] : d[31:0];
                exp_q.push_back({rr != 2'b00, p, w});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input logic ir);
        int n;
        n = 0;
        while (!inst_valid && n < 20) begin
            cycle(1'b0, 32'h0, 1'b0, ir);
            n++;
        end
        chk("wait_valid", inst_valid, 1'b1);
    endtask

    // ---------------- memory responder ----------------
    initial begin
        logic        rd_pending;
        logic [31:0] rd_addr;
        int          rd_wait;
        logic [1:0]  rd_resp;
        rd_pending = 1'b0;
        rd_addr    = 32'h0;
        rd_wait    = 0;
        rd_resp    = 2'b00;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rdata      = 64'h0;
        rresp      = 2'b00;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                rd_pending = 1'b0;
            end else if (arvalid && arready) begin
                chk("single_outstanding", rd_pending, 1'b0);
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL araddr_unexpected: got %h expected no request", araddr);
                end else begin
                    chk("araddr", araddr, addr_q.pop_front());
                end
                rd_resp    = (rresp_q.size() != 0) ? rresp_q.pop_front() : 2'b00;
                rd_pending = 1'b1;
                rd_addr    = araddr;
                rd_wait    = int'($urandom_range(rwait_max, rwait_min));
            end else if (rvalid && rready) begin
                rd_pending = 1'b0;
            end
            @(posedge clk);
            #1;
            case (ar_mode)
                1:       arready = 1'b1;
                2:       arready = 1'b0;
                default: arready = ($urandom_range(0, 2) != 0);
            endcase
            if (rd_pending) begin
                if (!rvalid) begin
                    if (rd_wait == 0) begin
                        rvalid = 1'b1;
                        rdata  = mem_read(rd_addr);
                        rresp  = rd_resp;
                    end else begin
                        rd_wait--;
                    end
                end
            end else begin
                rvalid = 1'b0;
                rdata  = {$urandom, $urandom};
                rresp  = 2'($urandom);
            end
        end
    end

    // ---------------- monitor ----------------
    logic        prev_arvalid = 1'b0;
    logic        prev_arready = 1'b0;
    logic [31:0] prev_araddr  = 32'h0;
    logic [64:0] mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_arvalid = 1'b0;
        end else begin
            if (prev_arvalid && !prev_arready) begin
                chk("arvalid_hold", arvalid, 1'b1);
                chk("araddr_hold", araddr, prev_araddr);
            end
            if (flush) chk("pc_ready_in_flush", pc_ready, 1'b0);
            if (inst_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_inst: got valid pc %h expected no valid", inst_pc);
                end else begin
                    mon_e = exp_q[0];
                    chk("inst", inst, mon_e[31:0]);
                    chk("inst_pc", inst_pc, mon_e[63:32]);
                    chk("inst_fault", inst_fault, mon_e[64]);
                    if (inst_ready && !flush) begin
                        exp_q.delete(0);
                        chk("fetch_cnt_at_hs", fetch_cnt, exp_cnt);
                        exp_cnt = exp_cnt + 64'd1;
                    end
                end
            end else begin
                chk("inst_nop_idle", inst, NOP);
                chk("fetch_cnt", fetch_cnt, exp_cnt);
            end
            prev_arvalid = arvalid;
            prev_arready = arready;
            prev_araddr  = araddr;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] p;
        logic [63:0] d;
        logic        pv, fl, ir, pv_hold;
        int          n;

        rst        = 1'b1;
        pc         = 32'h0;
        pc_valid   = 1'b0;
        flush      = 1'b0;
        inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst_fault", inst_fault, 1'b0);
        chk("rst_inst", inst, NOP);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fetch_cnt", fetch_cnt, 64'h0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_state", dut.state_q, IFU_IDLE);
        rst = 1'b0;

        // Aligned fetch, best-case latency.
        ar_mode = 1; rwait_min = 0; rwait_max = 0; force_resp = 0;
        cycle(1'b1, 32'h8000_0004, 1'b0, 1'b1);
        chk("a_accept", last_acc, 1'b1);
        chk("a_arvalid", arvalid, 1'b1);
        chk("a_araddr", araddr, 32'h8000_0000);
        chk("a_valid_c1", inst_valid, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("a_valid_c2", inst_valid, 1'b0);
        chk("a_rready", rready, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("a_valid_c3", inst_valid, 1'b1);
        chk("a_inst", inst, 32'h1234_5678);
        chk("a_inst_pc", inst_pc, 32'h8000_0004);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("a_fetch_cnt", fetch_cnt, 64'd1);
        chk("a_valid_done", inst_valid, 1'b0);

        // Back-pressure, then next pc taken in the completing cycle.
        d = mem_read(32'h8000_0008);
        cycle(1'b1, 32'h8000_0008, 1'b0, 1'b0);
        chk("b_accept", last_acc, 1'b1);
        wait_valid(1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h8000_0010, 1'b0, 1'b0);
            chk("b_pc_ready_low", last_acc, 1'b0);
            chk("b_valid_held", inst_valid, 1'b1);
            chk("b_inst_held", inst, d[31:0]);
            chk("b_pc_held", inst_pc, 32'h8000_0008);
            chk("b_fault_held", inst_fault, 1'b0);
        end
        cycle(1'b1, 32'h8000_0010, 1'b0, 1'b1);
        chk("b_next_accept", last_acc, 1'b1);
        chk("b_next_arvalid", arvalid, 1'b1);
        chk("b_next_araddr", araddr, 32'h8000_0010);
        wait_valid(1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("b_fetch_cnt", fetch_cnt, 64'd3);

        // Flush in DATA one cycle before rvalid.
        rwait_min = 1; rwait_max = 1;
        cycle(1'b1, 32'h8000_0020, 1'b0, 1'b0);
        chk("f_accept", last_acc, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("f_state_data", dut.state_q, IFU_DATA);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("f_state_drain", dut.state_q, IFU_DRAIN);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            chk("f_no_valid", inst_valid, 1'b0);
        end
        chk("f_state_idle", dut.state_q, IFU_IDLE);
        chk("f_fetch_cnt", fetch_cnt, 64'd3);

        // Misaligned pc faults without touching memory.
        rwait_min = 0; rwait_max = 0;
        cycle(1'b1, 32'h8000_0002, 1'b0, 1'b0);
        chk("m_accept", last_acc, 1'b1);
        chk("m_arvalid", arvalid, 1'b0);
        chk("m_valid", inst_valid, 1'b1);
        chk("m_fault", inst_fault, 1'b1);
        chk("m_inst", inst, 32'h0000_0013);
        chk("m_inst_pc", inst_pc, 32'h8000_0002);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("m_fetch_cnt", fetch_cnt, 64'd4);

        // Error response, upper word.
        force_resp = 2;
        d = mem_read(32'h8000_0100);
        cycle(1'b1, 32'h8000_0104, 1'b0, 1'b0);
        wait_valid(1'b0);
        chk("e_fault", inst_fault, 1'b1);
        chk("e_inst", inst, d[63:32]);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        force_resp = 0;

        // Reset while the address is waiting for arready.
        ar_mode = 2;
        cycle(1'b1, 32'h8000_0200, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("r_arvalid_before", arvalid, 1'b1);
        chk("r_state_addr", dut.state_q, IFU_ADDR);
        rst = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("r_arvalid_after", arvalid, 1'b0);
        chk("r_state_idle", dut.state_q, IFU_IDLE);
        chk("r_fetch_cnt", fetch_cnt, 64'd0);
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        rresp_q.delete();
        exp_cnt = 64'd0;

        // Random traffic.
        ar_mode = 0; rwait_min = 0; rwait_max = 3; force_resp = -1;
        pv_hold = 1'b0;
        pv = 1'b0;
        p = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            if (!pv_hold) begin
                pv = ($urandom_range(0, 3) != 0);
                p  = $urandom;
                if ($urandom_range(0, 9) == 0) p[1:0] = 2'($urandom_range(1, 3));
                else p[1:0] = 2'b00;
            end
            fl = ($urandom_range(0, 24) == 0);
            ir = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
            cycle(pv, p, fl, ir);
            pv_hold = pv && !last_acc;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050854_ifu.md
YSYX_22050854_IFU -- requirements
Module: ysyx_22050854_ifu

Interface
REQ-001 SHALL provide parameter NOP_INST, default 32'h0000_0013, the instruction word driven on inst when no valid fetch data is held.
REQ-002 SHALL provide ports in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  fetch address from the pc stage.
- pc_valid  in  1  pc is valid.
- pc_ready  out  1  the IFU accepts pc this cycle.
- flush  in  1  redirect; discard the in-flight fetch.
- arvalid  out  1  memory read-address valid.
- araddr  out  32  read address, {pc[31:3],3'b000}.
- arready  in  1  memory accepts the address.
- rvalid  in  1  read data valid.
- rdata  in  64  read data.
- rresp  in  2  read response; 2'b00 means OKAY.
- rready  out  1  the IFU accepts read data.
- inst  out  32  fetched instruction to the decoder.
- inst_pc  out  32  pc of inst.
- inst_valid  out  1  inst and inst_pc are valid.
- inst_ready  in  1  the decoder consumes inst.
- inst_fault  out  1  fetch fault, qualified by inst_valid.
- fetch_cnt  out  64  count of instructions delivered.

Function
REQ-003 SHALL implement an FSM with states IDLE, ADDR, DATA, DRAIN and OUT.
REQ-004 pc_ready SHALL be 1 when flush=0 and the FSM is either in IDLE, or in OUT with inst_ready=1.
REQ-005 On a pc handshake with pc[1:0]==0, the IFU SHALL latch pc and go to ADDR.
REQ-006 On a pc handshake with pc[1:0]!=0, the IFU SHALL go directly to OUT with inst=NOP_INST and inst_fault=1, and SHALL issue no memory request.
REQ-007 In ADDR: arvalid=1, and araddr SHALL stay stable until arready; on arready the FSM SHALL go to DATA, or to DRAIN if flush was seen while in ADDR.
REQ-008 Once asserted, arvalid SHALL NOT drop before arready, including when flush is asserted.
REQ-009 In DATA: rready=1; on rvalid the IFU SHALL capture the word and go to OUT.
- The captured word SHALL be rdata[63:32] when latched pc[2]=1, else rdata[31:0].
- inst_fault SHALL be set to (rresp!=2'b00).
REQ-010 Flush in DATA without rvalid SHALL go to DRAIN; flush in the same cycle as rvalid SHALL discard the data and go to IDLE.
REQ-011 In DRAIN: rready=1; on rvalid the data SHALL be discarded and the FSM SHALL go to IDLE.
REQ-012 In OUT: inst_valid=1, and inst, inst_pc and inst_fault SHALL be held stable until inst_ready.
- On inst_ready the FSM SHALL go to IDLE, or take the next pc if a pc handshake occurs in the same cycle.
- Flush in OUT SHALL drop inst_valid on the next cycle, without a handshake.
REQ-013 Flush SHALL take priority over pc_valid; no pc handshake SHALL occur in a flush cycle.
REQ-014 Best-case latency SHALL be 3 cycles from the pc handshake edge to inst_valid=1, with arready in the first cycle and rvalid in the next.
REQ-015 fetch_cnt SHALL increment by 1 on each inst_valid&inst_ready handshake, faults included, and SHALL wrap modulo 2^64.
REQ-016 At most one memory read SHALL be outstanding at any time.

Reset
REQ-017 On rst=1 at a clock edge, the FSM SHALL enter IDLE regardless of its current state, including mid-transaction.
REQ-018 After reset the outputs SHALL be:
- arvalid=0, rready=0, inst_valid=0, inst_fault=0.
- inst=NOP_INST, inst_pc=0, fetch_cnt=0.
- araddr=0.
REQ-019 The memory side SHALL share the same rst, so no response can arrive after reset for a pre-reset request.

Structure
REQ-020 Package ysyx_22050854_pkg SHALL hold:
- the IFU state enum;
- the NOP_INST value;
- RESP_OKAY=2'b00.
REQ-021 Word selection (rdata, pc[2] -> 32-bit word) SHALL live in the combinational sub-module ysyx_22050854_inst_sel.

Verification
REQ-022 Aligned fetch: pc=32'h8000_0004, arready and rvalid immediate, rdata=64'h1234_5678_0010_0073, inst_ready=1 -> araddr=32'h8000_0000, inst=32'h1234_5678, inst_pc=32'h8000_0004, inst_valid on cycle 3, fetch_cnt=1.
REQ-023 Back-pressure: inst_ready=0 for 4 cycles after inst_valid -> inst, inst_pc and inst_fault stable, pc_ready=0; on inst_ready=1 with pc_valid=1 -> next pc accepted the same cycle.
REQ-024 Flush in DATA: flush one cycle before rvalid -> FSM goes to DRAIN, the returned data is discarded, inst_valid never rises, fetch_cnt is unchanged.
REQ-025 Misaligned pc=32'h8000_0002 -> no arvalid; inst_valid=1, inst_fault=1, inst=32'h0000_0013 on the next cycle.
REQ-026 Error response: rresp=2'b10 -> inst_valid=1, inst_fault=1; reset asserted in ADDR -> arvalid=0 and state IDLE on the next cycle.
